// File: rtl/inter_4_tap_filter_pkg.sv
// -----------------------------------------------------------------------------
// inter_4_tap_filter_pkg
// Shared constants and types for the 4-tap half-sample interpolation filter.
//   TAP_C0..TAP_C3 : filter taps {-4, 36, 36, -4}, normalised by 2^SHIFT
//   SHIFT, ROUND   : normalisation shift and its rounding offset
//   SUM_W          : signed width of the weighted sum
//   PIX_MAX        : largest output pixel for the default 10-bit output
//   IDX_W          : width of the in-block sample index
// -----------------------------------------------------------------------------
package inter_4_tap_filter_pkg;

    localparam int TAP_C0  = -4;
    localparam int TAP_C1  = 36;
    localparam int TAP_C2  = 36;
    localparam int TAP_C3  = -4;
    localparam int SHIFT   = 6;
    localparam int ROUND   = 32;
    localparam int SUM_W   = 18;
    localparam int PIX_MAX = 1023;
    localparam int IDX_W   = 5;

    typedef logic signed [SUM_W-1:0] sum_t;

endpackage

// File: rtl/inter_4_mac.sv
// -----------------------------------------------------------------------------
// inter_4_mac
// Combinational 4-tap weighted sum: -4*x3 + 36*x2 + 36*x1 - 4*x0.
// Multiplications are done with shifts and adds (36x = 32x + 4x).
//   x3..x0 : unsigned pixels, x3 oldest, x0 newest
//   sum    : signed weighted sum, range -8184..73656 for 10-bit pixels
// -----------------------------------------------------------------------------
module inter_4_mac
    import inter_4_tap_filter_pkg::*;
#(
    parameter int IN = 10
) (
    input  logic [IN-1:0] x3,
    input  logic [IN-1:0] x2,
    input  logic [IN-1:0] x1,
    input  logic [IN-1:0] x0,
    output sum_t          sum
);

    sum_t e3, e2, e1, e0;

    always_comb begin
        // Zero-extend into the signed sum width before any arithmetic.
        e3  = sum_t'({{(SUM_W-IN){1'b0}}, x3});
        e2  = sum_t'({{(SUM_W-IN){1'b0}}, x2});
        e1  = sum_t'({{(SUM_W-IN){1'b0}}, x1});
        e0  = sum_t'({{(SUM_W-IN){1'b0}}, x0});
        sum = (e2 <<< 5) + (e2 <<< 2)
            + (e1 <<< 5) + (e1 <<< 2)
            - (e3 <<< 2) - (e0 <<< 2);
    end

endmodule

// File: rtl/inter_4_tap_filter.sv
// -----------------------------------------------------------------------------
// inter_4_tap_filter
// Streaming 4-tap half-sample interpolation filter, taps {-4,36,36,-4}/64.
// One pixel in and one pixel out per clock; blocks of SIZE_BLOCK outputs,
// each consuming SIZE_BLOCK+TAPS-1 input samples. A sample captured at edge k
// produces its output after edge k+2. Windows that straddle a block start
// (in-block index 0..TAPS-2 for the newest sample) produce 0.
//   clk      : clock, rising edge
//   in_rst   : asynchronous active-low reset
//   input_A1 : input pixel, sampled every rising edge
//   out_S1   : interpolated, rounded and clipped pixel (registered)
// -----------------------------------------------------------------------------
module inter_4_tap_filter
    import inter_4_tap_filter_pkg::*;
#(
    parameter int IN         = 10,
    parameter int OUT        = 10,
    parameter int SIZE_BLOCK = 16,
    parameter int TAPS       = 4
) (
    input  logic           clk,
    input  logic           in_rst,
    input  logic [IN-1:0]  input_A1,
    output logic [OUT-1:0] out_S1
);

    localparam int          PIX_HI   = (1 << OUT) - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE_BLOCK + TAPS - 2);
    localparam logic [IDX_W-1:0] FIRST_VLD = IDX_W'(TAPS - 1);

    // Round to nearest, shift down and saturate into the output range.
    function automatic logic [OUT-1:0] round_clip(input sum_t s);
        sum_t r;
        r = (s + sum_t'(ROUND)) >>> SHIFT;
        if (r < 0)
            return '0;
        else if (r > sum_t'(PIX_HI))
            return OUT'(PIX_HI);
        else
            return r[OUT-1:0];
    endfunction

    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] idx_p0;
    logic [IN-1:0]    t0_p0, t1_p0, t2_p0, t3_p0;
    sum_t             mac_sum;
    sum_t             sum_p1;
    logic             vld_p1;

    // ---- stage 0: tap chain and in-block index of the newest sample ----
    always_ff @(posedge clk or negedge in_rst) begin
        if (!in_rst) begin
            cnt    <= '0;
            idx_p0 <= '0;
            t0_p0  <= '0;
            t1_p0  <= '0;
            t2_p0  <= '0;
            t3_p0  <= '0;
        end else begin
            t0_p0  <= input_A1;
            t1_p0  <= t0_p0;
            t2_p0  <= t1_p0;
            t3_p0  <= t2_p0;
            idx_p0 <= cnt;
            cnt    <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
        end
    end

    inter_4_mac #(
        .IN (IN)
    ) u_mac (
        .x3  (t3_p0),
        .x2  (t2_p0),
        .x1  (t1_p0),
        .x0  (t0_p0),
        .sum (mac_sum)
    );

    // ---- stage 1: registered weighted sum ----
    // The window is inside one block once the newest sample has index >= TAPS-1.
    always_ff @(posedge clk or negedge in_rst) begin
        if (!in_rst) begin
            sum_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            sum_p1 <= mac_sum;
            vld_p1 <= (idx_p0 >= FIRST_VLD);
        end
    end

    // ---- stage 2: round, clip and blank invalid windows ----
    always_ff @(posedge clk or negedge in_rst) begin
        if (!in_rst) begin
            out_S1 <= '0;
        end else begin
            out_S1 <= vld_p1 ? round_clip(sum_p1) : '0;
        end
    end

endmodule

// File: tb/tb_inter_4_tap_filter.sv
module tb_inter_4_tap_filter;

    logic       clk;
    logic       in_rst;
    logic [9:0] input_A1;
    logic [9:0] out_S1;

    int checks;
    int failures;

    int stim [0:63];
    int expv [0:63];

    inter_4_tap_filter dut (
        .clk      (clk),
        .in_rst   (in_rst),
        .input_A1 (input_A1),
        .out_S1   (out_S1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Assert reset between edges, check the output clears at once, release
    // on a falling edge so the next rising edge captures block index 0.
    task automatic do_reset(input string tag);
        in_rst = 1'b0;
        #3;
        chk(tag, int'(out_S1), 0);
        @(negedge clk);
        in_rst = 1'b1;
    endtask

    // Feed n samples from stim plus two flush samples; out after edge j must
    // equal expv[j-2] (and 0 for the first two edges after reset).
    task automatic run_seq(input string tag, input int n);
        for (int j = 0; j < n + 2; j++) begin
            input_A1 = (j < n) ? 10'(stim[j]) : 10'd0;
            @(posedge clk);
            #1;
            if (j < 2)
                chk({tag, "_lat"}, int'(out_S1), 0);
            else
                chk($sformatf("%s[%0d]", tag, j - 2), int'(out_S1), expv[j - 2]);
            @(negedge clk);
        end
    endtask

    initial begin
        int nz0, nz1;
        checks   = 0;
        failures = 0;
        in_rst   = 1'b1;
        input_A1 = '0;
        #2;
        do_reset("reset_init");

        // Constant 512: 3 zeros then 512 for 16 outputs.
        for (int i = 0; i < 19; i++) begin
            stim[i] = 512;
            expv[i] = (i >= 3) ? 512 : 0;
        end
        run_seq("const512", 19);
        do_reset("reset_a");

        // Ramp of the block index: valid windows give newest-1.
        for (int i = 0; i < 19; i++) begin
            stim[i] = i;
            expv[i] = (i >= 3) ? i - 1 : 0;
        end
        run_seq("ramp", 19);
        do_reset("reset_b");

        // Overflow: samples 4,5 = 1023; window at idx 6 sums to 73656.
        for (int i = 0; i < 19; i++) begin
            stim[i] = (i == 4 || i == 5) ? 1023 : 0;
            expv[i] = 0;
        end
        expv[5] = 512;
        expv[6] = 1023;
        expv[7] = 512;
        run_seq("ovf", 19);
        do_reset("reset_c");

        // Underflow: samples 3,6 = 1023; window at idx 6 sums to -8184.
        for (int i = 0; i < 19; i++) begin
            stim[i] = (i == 3 || i == 6) ? 1023 : 0;
            expv[i] = 0;
        end
        expv[4] = 575;
        expv[5] = 575;
        expv[7] = 575;
        expv[8] = 575;
        run_seq("unf", 19);
        do_reset("reset_d");

        // Two back-to-back blocks with a ramp running across the wrap.
        for (int i = 0; i < 38; i++) begin
            stim[i] = i;
            expv[i] = ((i % 19) >= 3) ? i - 1 : 0;
        end
        run_seq("wrap", 38);
        nz0 = 0;
        nz1 = 0;
        // Re-run the second block's count from a fresh pass to count valid
        // outputs observed on the DUT pin.
        do_reset("reset_e");
        for (int j = 0; j < 40; j++) begin
            input_A1 = (j < 38) ? 10'(stim[j] + 100) : 10'd0;
            @(posedge clk);
            #1;
            if (j >= 2 && j < 21 && out_S1 != 0) nz0++;
            if (j >= 21 && j < 40 && out_S1 != 0) nz1++;
            @(negedge clk);
        end
        chk("wrap_cnt0", nz0, 16);
        chk("wrap_cnt1", nz1, 16);

        // Mid-block reset: out is 512 before, clears immediately, then the
        // next block restarts from index 0.
        do_reset("reset_f");
        for (int i = 0; i < 10; i++) begin
            stim[i] = 512;
            expv[i] = (i >= 3) ? 512 : 0;
        end
        run_seq("pre_rst", 10);
        do_reset("mid_rst");
        for (int i = 0; i < 19; i++) begin
            stim[i] = 512;
            expv[i] = (i >= 3) ? 512 : 0;
        end
        run_seq("post_rst", 19);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
